// File: rtl/sfft_pkg.sv
// Shared constants, state encoding and byte-lane helper for the SFFT readout controller.
package sfft_pkg;

   localparam int unsigned NFFT               = 128;
   localparam int unsigned SFFT_OUTPUT_WIDTH  = 32;
   localparam int unsigned TIME_COUNTER_WIDTH = 32;
   localparam int unsigned OVERRUN_WIDTH      = 16;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      COPY      = 2'd1,
      SWAP_WAIT = 2'd2
   } sfft_state_e;

   function automatic logic [7:0] le_byte(input logic [31:0] word, input logic [1:0] lane);
      logic [7:0] b;
      unique case (lane)
         2'd0: b = word[7:0];
         2'd1: b = word[15:8];
         2'd2: b = word[23:16];
         2'd3: b = word[31:24];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/sfft_readout_ctrl_if.sv
// Host read bus: byte address in, registered byte out.
interface sfft_readout_ctrl_if;

   logic        chipselect;
   logic [15:0] address;
   logic [7:0]  readdata;

   modport master (output chipselect, output address, input readdata);
   modport slave  (input chipselect, input address, output readdata);

endinterface

// File: rtl/sfft_bank_ram.sv
// Double-buffered bin storage: two banks of NFFT words, one write port, one registered read port.
module sfft_bank_ram #(
   parameter int unsigned NFFT  = 128,
   parameter int unsigned WIDTH = 32
) (
   input  logic                    clk_i,
   input  logic                    we_i,
   input  logic                    wbank_i,
   input  logic [$clog2(NFFT)-1:0] waddr_i,
   input  logic [WIDTH-1:0]        wdata_i,
   input  logic                    rbank_i,
   input  logic [$clog2(NFFT)-1:0] raddr_i,
   output logic [WIDTH-1:0]        rdata_o
);

   logic [WIDTH-1:0] mem_q [2*NFFT];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[{wbank_i, waddr_i}] <= wdata_i;
      end
      rdata_q <= mem_q[{rbank_i, raddr_i}];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sfft_readout_ctrl.sv
// Copies each new SFFT frame into a back bank and publishes it to the host by bank swap,
// never swapping while the host bus is active.
module sfft_readout_ctrl #(
   parameter int unsigned NFFT              = sfft_pkg::NFFT,
   parameter int unsigned SFFT_OUTPUT_WIDTH = sfft_pkg::SFFT_OUTPUT_WIDTH
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         sfft_valid,
   output logic [$clog2(NFFT)-1:0]      bin_sel,
   input  logic [SFFT_OUTPUT_WIDTH-1:0] bin_data,
   sfft_readout_ctrl_if.slave           host,
   output logic                         busy,
   output logic [31:0]                  frame_count,
   output logic [15:0]                  overrun_count
);

   import sfft_pkg::*;

   localparam int unsigned AW       = $clog2(NFFT);
   localparam logic [16:0] ADDR_END = 17'(4 * NFFT + 4);

   sfft_state_e                   state_q, state_d;
   logic                          valid_q;
   logic                          hold_q;
   logic [AW-1:0]                 bin_sel_q, bin_sel_d;
   logic                          front_q, front_d;
   logic                          ready_q, ready_d;
   logic [TIME_COUNTER_WIDTH-1:0] frame_count_q, frame_count_d;
   logic [TIME_COUNTER_WIDTH-1:0] timestamp_q, timestamp_d;
   logic [OVERRUN_WIDTH-1:0]      overrun_q, overrun_d;
   logic                          edge_det;
   logic                          ram_we;

   logic                          rd_zero_q, rd_zero_d;
   logic                          rd_ts_q, rd_ts_d;
   logic [1:0]                    rd_lane_q, rd_lane_d;
   logic [7:0]                    ts_byte_q, ts_byte_d;
   logic [AW-1:0]                 ram_raddr;
   logic [SFFT_OUTPUT_WIDTH-1:0]  ram_rdata;

   // hold_q masks a level that was already high during reset until it drops once
   assign edge_det = sfft_valid & ~valid_q & ~hold_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         valid_q       <= 1'b0;
         hold_q        <= sfft_valid;
         bin_sel_q     <= '0;
         front_q       <= 1'b0;
         ready_q       <= 1'b0;
         frame_count_q <= '0;
         timestamp_q   <= '0;
         overrun_q     <= '0;
      end else begin
         state_q       <= state_d;
         valid_q       <= sfft_valid;
         hold_q        <= hold_q & sfft_valid;
         bin_sel_q     <= bin_sel_d;
         front_q       <= front_d;
         ready_q       <= ready_d;
         frame_count_q <= frame_count_d;
         timestamp_q   <= timestamp_d;
         overrun_q     <= overrun_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      bin_sel_d     = bin_sel_q;
      front_d       = front_q;
      ready_d       = ready_q;
      frame_count_d = frame_count_q;
      timestamp_d   = timestamp_q;
      overrun_d     = overrun_q;
      ram_we        = 1'b0;

      if (edge_det && (state_q != IDLE) && (overrun_q != '1)) begin
         overrun_d = overrun_q + OVERRUN_WIDTH'(1);
      end

      unique case (state_q)
         IDLE: begin
            if (edge_det) begin
               state_d   = COPY;
               bin_sel_d = '0;
            end
         end
         COPY: begin
            ram_we = 1'b1;
            if (bin_sel_q == AW'(NFFT - 1)) begin
               bin_sel_d = '0;
               state_d   = SWAP_WAIT;
            end else begin
               bin_sel_d = bin_sel_q + AW'(1);
            end
         end
         SWAP_WAIT: begin
            if (!host.chipselect) begin
               front_d       = ~front_q;
               frame_count_d = frame_count_q + TIME_COUNTER_WIDTH'(1);
               timestamp_d   = frame_count_d;
               ready_d       = 1'b1;
               state_d       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Byte address 4i+4 maps to bin i; bank, timestamp byte and gating are all captured
   // in the address cycle so a swap on that edge cannot tear the returned byte.
   assign ram_raddr = host.address[AW+1:2] - AW'(1);

   always_comb begin
      rd_zero_d = ~ready_q | ({1'b0, host.address} >= ADDR_END);
      rd_ts_d   = (host.address[15:2] == 14'd0);
      rd_lane_d = host.address[1:0];
      ts_byte_d = le_byte(timestamp_q, host.address[1:0]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_zero_q <= 1'b1;
         rd_ts_q   <= 1'b0;
         rd_lane_q <= '0;
         ts_byte_q <= '0;
      end else begin
         rd_zero_q <= rd_zero_d;
         rd_ts_q   <= rd_ts_d;
         rd_lane_q <= rd_lane_d;
         ts_byte_q <= ts_byte_d;
      end
   end

   sfft_bank_ram #(
      .NFFT  (NFFT),
      .WIDTH (SFFT_OUTPUT_WIDTH)
   ) u_bank_ram (
      .clk_i   (clk),
      .we_i    (ram_we),
      .wbank_i (~front_q),
      .waddr_i (bin_sel_q),
      .wdata_i (bin_data),
      .rbank_i (front_q),
      .raddr_i (ram_raddr),
      .rdata_o (ram_rdata)
   );

   assign host.readdata = rd_zero_q ? 8'h00 :
                          rd_ts_q   ? ts_byte_q :
                                      le_byte(ram_rdata, rd_lane_q);

   assign bin_sel       = bin_sel_q;
   assign busy          = (state_q != IDLE);
   assign frame_count   = frame_count_q;
   assign overrun_count = overrun_q;

endmodule

// File: tb/tb_sfft_readout_ctrl.sv
// Directed bench for sfft_readout_ctrl with NFFT=16 and hand-computed expectations.
module tb_sfft_readout_ctrl;

   localparam int unsigned NFFT = 16;

   logic        clk;
   logic        reset;
   logic        sfft_valid;
   logic [3:0]  bin_sel;
   logic [31:0] bin_data;
   logic        busy;
   logic [31:0] frame_count;
   logic [15:0] overrun_count;
   logic [31:0] data_base;

   int n_cmp;
   int n_bad;

   sfft_readout_ctrl_if host_if ();

   sfft_readout_ctrl #(
      .NFFT              (NFFT),
      .SFFT_OUTPUT_WIDTH (32)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .sfft_valid    (sfft_valid),
      .bin_sel       (bin_sel),
      .bin_data      (bin_data),
      .host          (host_if.slave),
      .busy          (busy),
      .frame_count   (frame_count),
      .overrun_count (overrun_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bin i of the current frame carries data_base + i + 1.
   always_comb bin_data = data_base + 32'(bin_sel) + 32'd1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; presents the address and samples one cycle later.
   task automatic chk_rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
      host_if.address = a;
      @(negedge clk);
      check(tag, 32'(host_if.readdata), 32'(exp));
   endtask

   task automatic pulse();
      sfft_valid = 1'b1;
      @(negedge clk);
      sfft_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         if (!busy) break;
         @(negedge clk);
      end
      check("idle_timeout", 32'(busy), 32'd0);
   endtask

   initial begin
      n_cmp              = 0;
      n_bad              = 0;
      reset              = 1'b1;
      sfft_valid         = 1'b1;
      data_base          = 32'd0;
      host_if.chipselect = 1'b0;
      host_if.address    = 16'd0;

      // Reset with sfft_valid already high: must not be seen as an edge afterwards.
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frame_count", frame_count, 32'd0);
      check("rst_overrun", 32'(overrun_count), 32'd0);
      check("rst_bin_sel", 32'(bin_sel), 32'd0);
      check("rst_readdata", 32'(host_if.readdata), 32'd0);
      repeat (4) @(negedge clk);
      check("held_valid_no_edge", 32'(busy), 32'd0);
      sfft_valid = 1'b0;
      @(negedge clk);

      // Pre-frame: the whole map reads zero.
      for (int a = 0; a <= 4 * NFFT + 8; a++) begin
         chk_rd("preframe_rd", 16'(a), 8'h00);
      end

      // Basic frame: latency and published contents.
      pulse();
      check("copy_busy", 32'(busy), 32'd1);
      check("copy_bin0", 32'(bin_sel), 32'd0);
      @(negedge clk);
      check("copy_bin1", 32'(bin_sel), 32'd1);
      repeat (NFFT - 2) @(negedge clk);
      check("copy_last_bin", 32'(bin_sel), 32'(NFFT - 1));
      @(negedge clk);
      check("swapwait_busy", 32'(busy), 32'd1);
      check("swapwait_fc", frame_count, 32'd0);
      check("swapwait_bin_sel", 32'(bin_sel), 32'd0);
      @(negedge clk);
      check("swap_fc", frame_count, 32'd1);
      check("swap_idle", 32'(busy), 32'd0);
      chk_rd("f1_ts0", 16'd0, 8'h01);
      chk_rd("f1_ts1", 16'd1, 8'h00);
      chk_rd("f1_ts3", 16'd3, 8'h00);
      chk_rd("f1_b4", 16'd4, 8'h01);
      chk_rd("f1_b5", 16'd5, 8'h00);
      chk_rd("f1_b6", 16'd6, 8'h00);
      chk_rd("f1_b7", 16'd7, 8'h00);
      chk_rd("f1_last_bin", 16'(4 * NFFT), 8'h10);
      chk_rd("f1_past_end", 16'(4 * NFFT + 4), 8'h00);
      chk_rd("f1_top_addr", 16'hFFFF, 8'h00);

      // Host lock: swap is held off while chipselect is high.
      data_base          = 32'hA0B0_C000;
      host_if.chipselect = 1'b1;
      pulse();
      repeat (NFFT + 6) @(negedge clk);
      check("lock_busy", 32'(busy), 32'd1);
      check("lock_fc", frame_count, 32'd1);
      chk_rd("lock_old_b4", 16'd4, 8'h01);
      chk_rd("lock_old_ts", 16'd0, 8'h01);
      repeat (10) @(negedge clk);
      check("lock_busy_late", 32'(busy), 32'd1);
      host_if.chipselect = 1'b0;
      @(negedge clk);
      check("unlock_fc", frame_count, 32'd2);
      check("unlock_idle", 32'(busy), 32'd0);
      chk_rd("f2_ts0", 16'd0, 8'h02);
      chk_rd("f2_b4", 16'd4, 8'h01);
      chk_rd("f2_b5", 16'd5, 8'hC0);
      chk_rd("f2_b6", 16'd6, 8'hB0);
      chk_rd("f2_b7", 16'd7, 8'hA0);

      // Overrun: second edge 10 cycles after the first is dropped.
      data_base = 32'h0000_0200;
      pulse();
      repeat (9) @(negedge clk);
      pulse();
      check("ovr_count", 32'(overrun_count), 32'd1);
      wait_idle(4 * NFFT);
      check("ovr_fc", frame_count, 32'd3);
      repeat (5) @(negedge clk);
      check("ovr_no_second_frame", 32'(busy), 32'd0);
      chk_rd("f3_ts0", 16'd0, 8'h03);
      chk_rd("f3_b4", 16'd4, 8'h01);
      chk_rd("f3_b5", 16'd5, 8'h02);
      chk_rd("f3_bin5_lo", 16'd24, 8'h06);
      chk_rd("f3_bin5_hi", 16'd25, 8'h02);

      // Saturation: real overruns in COPY and SWAP_WAIT, then preload near the top.
      host_if.chipselect = 1'b1;
      pulse();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         pulse();
      end
      check("sat_count21", 32'(overrun_count), 32'd21);
      force dut.overrun_q = 16'hFFFC;
      #1;
      release dut.overrun_q;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         pulse();
      end
      check("sat_reach_ffff", 32'(overrun_count), 32'h0000_FFFF);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         pulse();
      end
      check("sat_hold_ffff", 32'(overrun_count), 32'h0000_FFFF);
      host_if.chipselect = 1'b0;
      wait_idle(4 * NFFT);
      check("sat_fc", frame_count, 32'd4);

      // Mid-copy reset: no swap, reads gated, next frame publishes as frame 1.
      data_base = 32'h0000_0300;
      pulse();
      repeat (NFFT / 2 - 1) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_fc", frame_count, 32'd0);
      check("mid_rst_overrun", 32'(overrun_count), 32'd0);
      check("mid_rst_bin_sel", 32'(bin_sel), 32'd0);
      chk_rd("mid_rst_ts0", 16'd0, 8'h00);
      chk_rd("mid_rst_b4", 16'd4, 8'h00);
      repeat (NFFT + 4) @(negedge clk);
      check("mid_rst_no_swap", frame_count, 32'd0);
      pulse();
      repeat (NFFT + 1) @(negedge clk);
      check("post_rst_fc", frame_count, 32'd1);
      check("post_rst_idle", 32'(busy), 32'd0);
      chk_rd("post_rst_ts0", 16'd0, 8'h01);
      chk_rd("post_rst_b4", 16'd4, 8'h01);
      chk_rd("post_rst_b5", 16'd5, 8'h03);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sfft_readout_ctrl.md
SFFT_READOUT_CTRL -- requirements
Module: sfft_readout_ctrl

Interface
REQ-001 Parameter NFFT, default 128: number of SFFT bins per frame; power of two, 4..256.
REQ-002 Parameter SFFT_OUTPUT_WIDTH, default 32: bin amplitude width in bits; fixed at 32 for this revision.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sfft_valid  input  1  SFFT pipeline OutputValid level, synchronous to clk; a new frame is signalled by its rising edge.
REQ-006 bin_sel  output  log2(NFFT)  index of the bin the controller is currently fetching from the SFFT output array.
REQ-007 bin_data  input  32  amplitude of bin bin_sel, combinationally valid in the same cycle.
REQ-008 chipselect  input  1  host bus access in progress.
REQ-009 address  input  16  host byte address.
REQ-010 readdata  output  8  registered host read byte.
REQ-011 busy  output  1  high while state is not IDLE.
REQ-012 frame_count  output  32  number of frames published since reset.
REQ-013 overrun_count  output  16  number of frames dropped, saturating.

Function
REQ-014 The controller SHALL detect a rising edge as sfft_valid=1 in cycle t with sfft_valid=0 in cycle t-1, using a registered copy of sfft_valid.
REQ-015 The state machine SHALL have three states: IDLE, COPY and SWAP_WAIT.
REQ-016 IDLE: on a detected edge the controller SHALL enter COPY in the next cycle with bin_sel=0.
REQ-017 COPY: each cycle the controller SHALL write bin_data into the back bank at index bin_sel and then increment bin_sel; after the write of bin NFFT-1 it SHALL enter SWAP_WAIT and return bin_sel to 0.
REQ-018 SWAP_WAIT: in the first cycle with chipselect=0 the controller SHALL swap front and back banks, increment frame_count, store the new frame_count as the front-bank timestamp, and return to IDLE.
REQ-019 SWAP_WAIT with chipselect=1: the controller SHALL hold the state with no swap, so a host read never sees a torn frame.
REQ-020 An edge detected while in COPY or SWAP_WAIT SHALL increment overrun_count, saturating at 16'hFFFF; the current copy SHALL continue unaffected and the new frame SHALL be dropped.
REQ-021 Minimum latency from edge cycle t to swap SHALL be NFFT+2 cycles, when chipselect=0 throughout.
REQ-022 Read map, from the front bank only:
- bytes 0-3: timestamp, little-endian (byte 0 = bits 7:0).
- bytes 4i+4 .. 4i+7: bin i, little-endian, for 0 <= i < NFFT.
- all addresses >= 4*NFFT+4: 0.
REQ-023 readdata SHALL update every cycle, one cycle after address is presented, independent of chipselect.
REQ-024 Before the first swap after reset, every address SHALL read 0; a frame_ready flag SHALL gate this.

Reset
REQ-025 On reset the controller SHALL enter IDLE, with bin_sel=0, busy=0, frame_count=0, overrun_count=0, readdata=0, front bank=0, frame_ready=0 and the edge register=0.
REQ-026 Reset SHALL abort any COPY or SWAP_WAIT in progress with no swap; bank RAM contents are not cleared.
REQ-027 An sfft_valid held high through reset release SHALL NOT count as an edge.

Structure
REQ-028 NFFT, SFFT_OUTPUT_WIDTH, TIME_COUNTER_WIDTH (32) and the state enum SHALL live in a shared package, sfft_pkg.
REQ-029 Bank storage SHALL be one sub-module, sfft_bank_ram: two banks of NFFT x 32 bits, one write port and one registered read port, with the bank select supplied by the controller.

Verification
REQ-030 Basic frame: reset, one sfft_valid pulse, bin_data=i+1 for bin i, chipselect=0 -> swap at t+NFFT+2; frame_count=1; byte 0 reads 8'h01; bytes 4-7 read 01,00,00,00; byte 4*NFFT+4 reads 0.
REQ-031 Host lock: chipselect=1 from t to t+NFFT+20 -> busy stays high, no swap until the first cycle with chipselect=0, then frame_count=1 and the old front data is intact up to that point.
REQ-032 Overrun: two edges 10 cycles apart -> overrun_count=1, frame_count=1, and the published data is from the first frame.
REQ-033 Saturation: force 65540 overruns -> overrun_count=16'hFFFF.
REQ-034 Mid-copy reset: assert reset at t+NFFT/2 -> IDLE, frame_ready=0, all reads return 0, and the next frame publishes normally with frame_count=1.
REQ-035 Pre-frame read: read addresses 0..4*NFFT+8 after reset -> every readdata=0, each with 1-cycle latency.
